// File: rtl/result_monitor_pkg.sv
// Shared types and constants for the result monitor.
// Holds the FSM states, the hex-to-7-segment table and counter limits.
package result_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_ACCUM   = 2'd2
    } state_e;

    localparam logic [15:0] ERR_MAX  = 16'hFFFF;
    localparam logic [15:0] FRM_MAX  = 16'hFFFF;
    localparam logic [7:0]  DROP_MAX = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost literal.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,
        8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99,
        8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Four-digit multiplexed hex display scanner.
// seg and an are registered so both follow the digit index edge.
module seg_scan
    import result_monitor_pkg::*;
#(
    parameter int SCAN_DIV = 1 << 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] value,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q;
    logic [1:0]    dig_q;
    logic [1:0]    dig_d;
    logic [3:0]    nib;
    logic [7:0]    seg_q;
    logic [3:0]    an_q;

    // Advance the digit when the divider wraps; pick its nibble.
    always_comb begin
        dig_d = dig_q;
        if (&cnt_q) begin
            dig_d = dig_q + 2'd1;
        end
        nib = value[3:0];
        unique case (dig_d)
            2'd0: nib = value[3:0];
            2'd1: nib = value[7:4];
            2'd2: nib = value[11:8];
            2'd3: nib = value[15:12];
            default: nib = value[3:0];
        endcase
    end

    // Divider, digit index and registered display outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= '0;
            dig_q <= 2'd0;
            seg_q <= SEG_LUT[0];
            an_q  <= 4'b1110;
        end else begin
            cnt_q <= cnt_q + CW'(1);
            dig_q <= dig_d;
            seg_q <= SEG_LUT[nib];
            an_q  <= ~(4'b0001 << dig_d);
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: rtl/result_monitor.sv
// Compares sent and received bytes, accumulating bit-error statistics.
// Three-state pipeline: latch, XOR/popcount, accumulate.
module result_monitor
    import result_monitor_pkg::*;
#(
    parameter int SCAN_DIV = 1 << 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [7:0]  sent_seq,
    input  logic [7:0]  recv_seq,
    input  logic        recv_valid,
    input  logic        clear,
    output logic        busy,
    output logic        frame_done,
    output logic [3:0]  err_bits,
    output logic        match,
    output logic [15:0] err_total,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    state_e      state_q;
    state_e      state_d;
    logic [7:0]  sent_q;
    logic [7:0]  recv_q;
    logic [7:0]  diff_q;
    logic [3:0]  pop_q;
    logic        done_q;
    logic [3:0]  errb_q;
    logic        match_q;
    logic [15:0] tot_q;
    logic [15:0] tot_d;
    logic [15:0] frm_q;
    logic [15:0] frm_d;
    logic [7:0]  drp_q;
    logic [7:0]  drp_d;
    logic [16:0] sum;

    // Next-state logic: a strobe starts a frame, the rest is fixed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (recv_valid) state_d = S_COMPARE;
            S_COMPARE: state_d = S_ACCUM;
            S_ACCUM:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Saturating counters; clear overrides any same-cycle increment.
    always_comb begin
        sum   = {1'b0, tot_q} + {13'd0, pop_q};
        tot_d = tot_q;
        frm_d = frm_q;
        drp_d = drp_q;
        if (state_q == S_ACCUM) begin
            tot_d = sum[16] ? ERR_MAX : sum[15:0];
            if (frm_q != FRM_MAX) begin
                frm_d = frm_q + 16'd1;
            end
        end
        if (recv_valid && (state_q != S_IDLE) && (drp_q != DROP_MAX)) begin
            drp_d = drp_q + 8'd1;
        end
        if (clear) begin
            tot_d = '0;
            frm_d = '0;
            drp_d = '0;
        end
    end

    // State, frame pipeline and result registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            sent_q  <= '0;
            recv_q  <= '0;
            diff_q  <= '0;
            pop_q   <= '0;
            done_q  <= 1'b0;
            errb_q  <= '0;
            match_q <= 1'b0;
            tot_q   <= '0;
            frm_q   <= '0;
            drp_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && recv_valid) begin
                sent_q <= sent_seq;
                recv_q <= recv_seq;
            end
            if (state_q == S_COMPARE) begin
                diff_q <= sent_q ^ recv_q;
                pop_q  <= popcount8(sent_q ^ recv_q);
            end
            done_q <= (state_q == S_ACCUM);
            if (state_q == S_ACCUM) begin
                errb_q  <= pop_q;
                match_q <= (diff_q == 8'd0);
            end
            tot_q <= tot_d;
            frm_q <= frm_d;
            drp_q <= drp_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
    assign err_bits   = errb_q;
    assign match      = match_q;
    assign err_total  = tot_q;
    assign frame_cnt  = frm_q;
    assign drop_cnt   = drp_q;

    seg_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk_sys(clk_sys),
        .reset  (reset),
        .value  (tot_q),
        .seg    (seg),
        .an     (an)
    );

endmodule

// File: tb/tb_result_monitor.sv
// Scoreboard bench for result_monitor with a cycle-level frame model.
// Stimulus pushes expected frames; a monitor pops on frame_done.
module tb_result_monitor;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sent_seq = '0;
    logic [7:0]  recv_seq = '0;
    logic        recv_valid = 1'b0;
    logic        clear = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [3:0]  err_bits;
    logic        match;
    logic [15:0] err_total;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
    logic [7:0]  seg;
    logic [3:0]  an;

    always #5 clk_sys = ~clk_sys;

    result_monitor #(
        .SCAN_DIV(4)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .sent_seq  (sent_seq),
        .recv_seq  (recv_seq),
        .recv_valid(recv_valid),
        .clear     (clear),
        .busy      (busy),
        .frame_done(frame_done),
        .err_bits  (err_bits),
        .match     (match),
        .err_total (err_total),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .seg       (seg),
        .an        (an)
    );

    typedef struct {
        int eb;
        int m;
        int tot;
        int frm;
    } exp_t;

    exp_t sb[$];

    // Standard active-low hex font, {dp,g,f,e,d,c,b,a}.
    logic [7:0] hex7 [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = -10;
    int next_ok = 0;
    int rst_cyc = 0;
    int m_tot = 0;
    int m_frm = 0;
    int m_drp = 0;
    bit pend = 0;
    int pend_e2 = 0;
    int pend_err = 0;
    bit mon_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // Frame-level reference: accept, drop, accumulate, clear, reset.
    task automatic model(input bit rv, input logic [7:0] s, input logic [7:0] r,
                         input bit clr, input bit rst);
        exp_t e;
        bit push;
        push = 0;
        e = '{0, 0, 0, 0};
        if (rst) begin
            pend = 0;
            acc_cyc = -10;
            next_ok = cyc + 1;
            m_tot = 0;
            m_frm = 0;
            m_drp = 0;
            rst_cyc = cyc;
        end else begin
            if (pend && pend_e2 == cyc) begin
                m_tot = (m_tot + pend_err > 65535) ? 65535 : m_tot + pend_err;
                m_frm = (m_frm == 65535) ? 65535 : m_frm + 1;
                pend = 0;
                push = 1;
                e.eb = pend_err;
                e.m = (pend_err == 0) ? 1 : 0;
            end
            if (rv) begin
                if (cyc >= next_ok) begin
                    pend = 1;
                    pend_err = $countones(s ^ r);
                    pend_e2 = cyc + 2;
                    next_ok = cyc + 3;
                    acc_cyc = cyc;
                end else if (m_drp < 255) begin
                    m_drp++;
                end
            end
            if (clr) begin
                m_tot = 0;
                m_frm = 0;
                m_drp = 0;
            end
            if (push) begin
                e.tot = m_tot;
                e.frm = m_frm;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drive(input bit rv, input logic [7:0] s, input logic [7:0] r,
                         input bit clr, input bit rst);
        @(negedge clk_sys);
        #1;
        recv_valid = rv;
        sent_seq = s;
        recv_seq = r;
        clear = clr;
        reset = rst;
        model(rv, s, r, clr, rst);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'h00, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, 8'h00, 8'h00, 0, 1);
        idle(1);
    endtask

    task automatic frame(input logic [7:0] s, input logic [7:0] r);
        drive(1, s, r, 0, 0);
        idle(2);
    endtask

    task automatic scan_chk();
        int k;
        int d;
        k = (cyc - 1) - rst_cyc - 1;
        d = (k / 4) % 4;
        chk("scan_an", int'(an), int'(~(4'b0001 << d) & 4'hF));
        chk("scan_seg", int'(seg), int'(hex7[(m_tot >> (4 * d)) & 15]));
    endtask

    // Monitor: busy every cycle, result fields on each frame_done.
    always @(negedge clk_sys) begin
        exp_t e;
        if (mon_en) begin
            chk("busy", int'(busy),
                (cyc - acc_cyc == 1 || cyc - acc_cyc == 2) ? 1 : 0);
            if (frame_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_done: pulse with no frame pending at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("err_bits", int'(err_bits), e.eb);
                    chk("match", int'(match), e.m);
                    chk("err_total", int'(err_total), e.tot);
                    chk("frame_cnt", int'(frame_cnt), e.frm);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 8'h00, 8'h00, 0, 1);
        drive(0, 8'h00, 8'h00, 0, 1);
        mon_en = 1;
        idle(1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_err_bits", int'(err_bits), 0);
        chk("rst_match", int'(match), 0);
        chk("rst_err_total", int'(err_total), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_an", int'(an), 4'b1110);
        chk("rst_seg", int'(seg), 8'hC0);

        for (int i = 0; i < 16; i++) begin
            scan_chk();
            idle(1);
        end

        drive(1, 8'hA5, 8'hA5, 0, 0);
        idle(2);
        chk("lat_early", int'(frame_done), 0);
        idle(1);
        chk("lat_done", int'(frame_done), 1);
        chk("m1_match", int'(match), 1);
        chk("m1_frame_cnt", int'(frame_cnt), 1);
        idle(1);
        chk("lat_pulse_width", int'(frame_done), 0);

        for (int i = 0; i < 5; i++) frame(8'hFF, 8'h0F);
        idle(4);
        chk("e5_err_bits", int'(err_bits), 4);
        chk("e5_match", int'(match), 0);
        chk("e5_err_total", int'(err_total), 20);
        for (int i = 0; i < 20; i++) begin
            scan_chk();
            idle(1);
        end

        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1, 8'($urandom), 8'($urandom), 0, 0);
        idle(4);
        chk("busy_drop_cnt", int'(drop_cnt), m_drp);
        chk("busy_frame_cnt", int'(frame_cnt), m_frm);
        chk("busy_drop_two", m_drp, 2);

        drive(1, 8'hFF, 8'h00, 0, 0);
        idle(1);
        drive(1, 8'h12, 8'h34, 1, 0);
        idle(1);
        chk("clr_done", int'(frame_done), 1);
        chk("clr_err_bits", int'(err_bits), 8);
        idle(3);
        chk("clr_err_total", int'(err_total), 0);
        chk("clr_frame_cnt", int'(frame_cnt), 0);
        chk("clr_drop_cnt", int'(drop_cnt), 0);

        frame(8'h0F, 8'h00);
        idle(2);
        drive(1, 8'hFF, 8'h00, 0, 0);
        drive(0, 8'h00, 8'h00, 0, 1);
        idle(5);
        chk("abort_err_total", int'(err_total), 0);
        chk("abort_frame_cnt", int'(frame_cnt), 0);
        chk("abort_drop_cnt", int'(drop_cnt), 0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 3) == 0, 8'($urandom), 8'($urandom),
                  ($urandom % 97) == 0, ($urandom % 251) == 0);
        end
        idle(4);
        chk("rnd_err_total", int'(err_total), m_tot);
        chk("rnd_frame_cnt", int'(frame_cnt), m_frm);
        chk("rnd_drop_cnt", int'(drop_cnt), m_drp);

        do_reset();
        for (int i = 0; i < 400; i++)
            drive(1, 8'($urandom), 8'($urandom), 0, 0);
        idle(4);
        chk("drop_sat", int'(drop_cnt), 255);
        chk("drop_sat_model", int'(drop_cnt), m_drp);

        do_reset();
        for (int i = 0; i < 8191; i++) frame(8'hFF, 8'h00);
        frame(8'hF0, 8'h00);
        idle(2);
        chk("pre_sat_total", int'(err_total), 16'hFFFC);
        frame(8'hFF, 8'h00);
        idle(2);
        chk("sat_total", int'(err_total), 16'hFFFF);
        frame(8'hFF, 8'h00);
        frame(8'h01, 8'h00);
        idle(2);
        chk("sat_hold", int'(err_total), 16'hFFFF);
        chk("sat_frame_cnt", int'(frame_cnt), m_frm);

        idle(4);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
